fetch_sequencer: RTL

Upstream stage of the CPU core. Fetches each instruction from the synchronous instruction ROM at the address given by the core's `instruction_pointer`, holds it stable, and generates the single-cycle `enable` that advances the core. Supports free-running (turbo) execution and push-button single-stepping, and keeps a retired-instruction counter for debug display.

---
 rtl/fetch_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// ---------------
// Upstream stage of the CPU core. It fetches the instruction at the core's
// instruction_pointer from the instruction ROM and holds it stable. It then
// issues a one-cycle enable that advances the core. Two modes are supported:
// free-running (turbo) and push-button single-step. A retired-instruction
// counter is kept for the debug display.
//
// Optional feature: define STEP_DEBOUNCE_EN to add a debounce counter on the
// synchronized step button (DEBOUNCE_CYCLES stable-high cycles).
//
// Ports
//   clk                  system clock, rising edge
//   reset                asynchronous, active-high reset
//   turbo                1 = free-run, 0 = single-step
//   step                 raw push button, active-high, asynchronous
//   instruction_pointer  current instruction address from the core
//   rom_data             ROM read data for rom_addr
//   rom_addr             registered ROM address
//   instruction          registered instruction presented to the core
//   enable               one-cycle pulse that advances the core
//   busy                 high while a fetch/execute sequence is in progress
//   retired_count        enable pulses issued since reset (wraps)
`timescale 1ns/1ps

module fetch_sequencer #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter int          CNT_WIDTH       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 turbo,
   input  logic                 step,
   input  logic [7:0]           instruction_pointer,
   input  logic [31:0]          rom_data,
   output logic [7:0]           rom_addr,
   output logic [31:0]          instruction,
   output logic                 enable,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] retired_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2,
      S_EXEC  = 2'd3
   } state_t;

   state_t state_reg, state_next;

   logic                 step_meta_reg;
   logic                 step_sync_reg;
   logic                 step_level;
   logic                 step_prev_reg;
   logic                 step_rise;
   logic                 step_pending_reg;
   logic                 take_step;

   logic [7:0]           rom_addr_reg;
   logic [31:0]          instruction_reg;
   logic                 enable_reg;
   logic                 busy_reg;
   logic [CNT_WIDTH-1:0] retired_reg;

   // Two-flop synchronizer for the asynchronous push button.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_meta_reg <= 1'b0;
         step_sync_reg <= 1'b0;
      end else begin
         step_meta_reg <= step;
         step_sync_reg <= step_meta_reg;
      end
   end

`ifdef STEP_DEBOUNCE_EN
   // The counter saturates at DEBOUNCE_CYCLES. Any low sample clears it.
   // The level is gated by the live synchronized sample, so it falls
   // on the first low cycle without waiting for the counter.
   logic [15:0] debounce_cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         debounce_cnt_reg <= 16'd0;
      end else if (!step_sync_reg) begin
         debounce_cnt_reg <= 16'd0;
      end else if (debounce_cnt_reg != DEBOUNCE_CYCLES) begin
         debounce_cnt_reg <= debounce_cnt_reg + 16'd1;
      end
   end

   assign step_level = step_sync_reg && (debounce_cnt_reg == DEBOUNCE_CYCLES);
`else
   // No debounce: the synchronized level is used directly.
   logic unused_debounce;
   assign unused_debounce = ^DEBOUNCE_CYCLES;
   assign step_level      = step_sync_reg;
`endif

   assign step_rise = step_level && !step_prev_reg;

   // step_pending holds only one request. While it is set, further edges are
   // lost. Turbo mode has no use for a queued step, so turbo clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_prev_reg    <= 1'b0;
         step_pending_reg <= 1'b0;
      end else begin
         step_prev_reg <= step_level;
         if (turbo) begin
            step_pending_reg <= 1'b0;
         end else if (take_step) begin
            step_pending_reg <= 1'b0;
         end else if (step_rise) begin
            step_pending_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // turbo is only looked at in IDLE and EXEC. A sequence that has started
   // therefore always runs to its enable.
   always_comb begin
      state_next = state_reg;
      take_step  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (turbo) begin
               state_next = S_FETCH;
            end else if (step_pending_reg) begin
               take_step  = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_FETCH: state_next = S_WAIT;
         S_WAIT:  state_next = S_EXEC;
         S_EXEC:  state_next = turbo ? S_FETCH : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // The address is captured at the end of FETCH, not on entry. The core
   // moves its pointer on the EXEC edge, so a branch target is picked up by
   // the next fetch. enable and busy are decoded from the next state. This
   // makes them registered and aligned with the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rom_addr_reg    <= 8'h00;
         instruction_reg <= 32'h0;
         enable_reg      <= 1'b0;
         busy_reg        <= 1'b0;
         retired_reg     <= '0;
      end else begin
         if (state_reg == S_FETCH) begin
            rom_addr_reg <= instruction_pointer;
         end
         if (state_reg == S_WAIT) begin
            instruction_reg <= rom_data;
         end
         if (state_reg == S_EXEC) begin
            retired_reg <= retired_reg + 1'b1;
         end
         enable_reg <= (state_next == S_EXEC);
         busy_reg   <= (state_next != S_IDLE);
      end
   end

   assign rom_addr      = rom_addr_reg;
   assign instruction   = instruction_reg;
   assign enable        = enable_reg;
   assign busy          = busy_reg;
   assign retired_count = retired_reg;

endmodule
